output_mem: RTL
===============

OUTPUT_MEM -- requirements
Module: output_mem

Interface
REQ-001 SHALL use parameters from the ComputeCommon package: PE_NUM (default 16, lane count); PSUM_W (default 24, partial-sum bits); OCH_DEPTH (default 32, entries per lane); OCH_W = clog2(OCH_DEPTH).
REQ-002 SHALL have one clock; reset is synchronous and active-high. Ports: clk  in  1  sole clock; rst  in  1  synchronous active-high reset.
REQ-003 SHALL have port pea2omem  in  PEA_to_OMEM  per-lane ofmap[PE_NUM][PSUM_W], out_ch[PE_NUM][OCH_W], out_valid (write-back from PE array).
REQ-004 SHALL have port rd_en  in  1  psum lookup request.
REQ-005 SHALL have port rd_ch  in  PE_NUM*OCH_W  per-lane lookup address.
REQ-006 SHALL have port omem2pea  out  OMEM_to_PEA  psum[PE_NUM][PSUM_W], acc_valid.
REQ-007 SHALL have port center_done  in  1  single-cycle pulse ending accumulation for the current center.
REQ-008 SHALL have port busy  out  1  high while draining.
REQ-009 SHALL have port drain_valid  out  1, drain_ready  in  1  drain handshake.
REQ-010 SHALL have port drain_data  out  PE_NUM*PSUM_W  one entry from every lane, lane 0 in LSBs.
REQ-011 SHALL have port drain_ch  out  OCH_W  entry address of the current beat.
REQ-012 SHALL have port drain_last  out  1  marks the final beat (drain_ch = OCH_DEPTH-1).
REQ-013 SHALL have port wr_drop_err  out  1  sticky flag: a write arrived while draining.

Function
REQ-014 SHALL keep, per lane, OCH_DEPTH entries of PSUM_W data plus one entry-valid bit each.
REQ-015 SHALL, when out_valid=1 in state ACC, write ofmap[i] to lane i entry out_ch[i] and set its valid bit, all lanes in the same cycle.
REQ-016 SHALL register lookups with 1-cycle latency: acc_valid(t+1) = rd_en(t); psum[i](t+1) = entry rd_ch[i] if its valid bit is set, else 0.
REQ-017 SHALL forward write-first on a same-cycle write and lookup to the same lane/address: the lookup returns the new ofmap value.
REQ-018 SHALL hold psum and acc_valid at 0 in cycles without a preceding rd_en.
REQ-019 SHALL implement FSM states ACC (reset state) and DRAIN; ACC -> DRAIN on center_done; DRAIN -> ACC on the handshake of the drain_last beat.
REQ-020 SHALL, in DRAIN, walk a counter from 0 to OCH_DEPTH-1, with drain_valid=1, drain_ch=counter, and drain_data=entry data, or 0 when the valid bit is clear.
REQ-021 SHALL advance the counter only on drain_valid & drain_ready, and clear the valid bits of all lanes at that address on the same edge.
REQ-022 SHALL hold drain_data, drain_ch and drain_last stable while drain_valid=1 and drain_ready=0.
REQ-023 SHALL make the first drain beat valid on the cycle after center_done (1-cycle entry latency); busy = (state==DRAIN).
REQ-024 SHALL, in DRAIN, discard out_valid writes and set wr_drop_err until reset; lookups remain serviced.
REQ-025 SHALL ignore center_done while in DRAIN and ignore center_done while out_valid is high in the same ACC cycle only for the transition timing (the write completes first, then DRAIN).

Reset
REQ-026 SHALL, on rst=1 at a clk edge: state=ACC, counter=0, all valid bits=0, psum=0, acc_valid=0, drain_valid=0, drain_data=0, drain_ch=0, drain_last=0, busy=0, wr_drop_err=0.
REQ-027 SHALL abort a drain when reset occurs mid-drain; undrained entries are lost; data storage itself need not be reset.

Structure
REQ-028 SHALL place PE_NUM, PSUM_W, OCH_DEPTH, OCH_W, PEA_to_OMEM and OMEM_to_PEA in ComputeCommon; the drain beat width is derived there.
REQ-029 SHALL instantiate one sub-module, omem_bank (one lane: storage, valid bits, lookup/forward path), PE_NUM times; the FSM and drain counter are shared at top level.

Verification (PE_NUM=4, OCH_DEPTH=8, PSUM_W=24)
REQ-030 SHALL verify fresh lookup: after reset, rd_en=1, rd_ch=3 on all lanes -> next cycle acc_valid=1, psum=0 on all lanes.
REQ-031 SHALL verify write then read: write ofmap={10,20,30,40} to ch 5, then lookup ch 5 -> psum={10,20,30,40}.
REQ-032 SHALL verify forwarding: same-cycle write 0x123 to ch 2 plus lookup of ch 2 -> psum=0x123 the next cycle.
REQ-033 SHALL verify drain with backpressure: ch 0 and ch 7 written, center_done, drain_ready toggled 1/0 -> 8 beats, ch 0..7 in order, unwritten beats 0, drain_last only on ch 7, data stable during stalls, busy drops after the last beat, and a subsequent lookup returns 0.
REQ-034 SHALL verify drop error: out_valid during DRAIN -> write ignored, wr_drop_err=1 persists until rst.
REQ-035 SHALL verify reset mid-drain: rst at beat 3 -> next cycle state ACC, drain_valid=0, all lookups return 0.

Source files
------------

// File: rtl/output_mem_pkg.sv
// ComputeCommon: lane/partial-sum sizing and the PE-array <-> output-memory bus types.
// Drain beat width is derived here so producers and consumers agree on packing.
package ComputeCommon;
  localparam int PE_NUM    = 16;
  localparam int PSUM_W    = 24;
  localparam int OCH_DEPTH = 32;
  localparam int OCH_W     = $clog2(OCH_DEPTH);
  localparam int DRAIN_W   = PE_NUM * PSUM_W;

  typedef struct packed {
    logic [PE_NUM-1:0][PSUM_W-1:0] ofmap;
    logic [PE_NUM-1:0][OCH_W-1:0]  out_ch;
    logic                          out_valid;
  } PEA_to_OMEM;

  typedef struct packed {
    logic [PE_NUM-1:0][PSUM_W-1:0] psum;
    logic                          acc_valid;
  } OMEM_to_PEA;

  typedef enum logic {
    ST_ACC   = 1'b0,
    ST_DRAIN = 1'b1
  } omem_state_e;
endpackage

// File: rtl/output_mem_if.sv
// Bundle of PE-array write-back/lookup buses and the drain stream of output_mem.
// slave = the memory, master = the PE array / drain consumer side.
interface output_mem_if;
  import ComputeCommon::*;

  PEA_to_OMEM              pea2omem;
  logic                    rd_en;
  logic [PE_NUM*OCH_W-1:0] rd_ch;
  OMEM_to_PEA              omem2pea;
  logic                    center_done;
  logic                    busy;
  logic                    drain_valid;
  logic                    drain_ready;
  logic [DRAIN_W-1:0]      drain_data;
  logic [OCH_W-1:0]        drain_ch;
  logic                    drain_last;
  logic                    wr_drop_err;

  modport slave (
    input  pea2omem, rd_en, rd_ch, center_done, drain_ready,
    output omem2pea, busy, drain_valid, drain_data, drain_ch, drain_last, wr_drop_err
  );

  modport master (
    output pea2omem, rd_en, rd_ch, center_done, drain_ready,
    input  omem2pea, busy, drain_valid, drain_data, drain_ch, drain_last, wr_drop_err
  );
endinterface

// File: rtl/output_mem_bank.sv
// One lane of partial-sum storage: lookup is 1 cycle with write-first forwarding;
// drain read is combinational at the shared drain address, cleared on handshake.
module omem_bank
  import ComputeCommon::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [OCH_W-1:0]  wr_ch,
  input  logic [PSUM_W-1:0] wr_dat,
  input  logic              rd_en,
  input  logic [OCH_W-1:0]  rd_ch,
  output logic [PSUM_W-1:0] rd_psum,
  input  logic [OCH_W-1:0]  drain_ch,
  input  logic              drain_clr,
  output logic [PSUM_W-1:0] drain_dat
);
  logic [PSUM_W-1:0]    mem [OCH_DEPTH];
  logic [OCH_DEPTH-1:0] vld;

  // Data array is never reset; the valid bits alone decide what is visible.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ch] <= wr_dat;
  end

  // Writes only happen in ACC and clears only in DRAIN, so they never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
    end else begin
      if (drain_clr) vld[drain_ch] <= 1'b0;
      if (wr_en)     vld[wr_ch]    <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !rd_en)                rd_psum <= '0;
    else if (wr_en && wr_ch == rd_ch) rd_psum <= wr_dat;
    else if (vld[rd_ch])              rd_psum <= mem[rd_ch];
    else                              rd_psum <= '0;
  end

  assign drain_dat = vld[drain_ch] ? mem[drain_ch] : '0;
endmodule

// File: rtl/output_mem.sv
// Per-lane psum store with 1-cycle lookup; after center_done it streams every entry
// address once (valid/ready, held on stall), dropping PE writes while draining.
module output_mem
  import ComputeCommon::*;
(
  input  logic        clk,
  input  logic        rst,
  output_mem_if.slave omem
);
  omem_state_e                   state_q, state_d;
  logic [OCH_W-1:0]              cnt_q;
  logic                          drain_vld;
  logic                          last_beat;
  logic                          hs;
  logic                          wr_en;
  logic                          acc_valid_q;
  logic                          drop_err_q;
  logic [PE_NUM-1:0][PSUM_W-1:0] rd_psum;
  logic [PE_NUM-1:0][PSUM_W-1:0] bank_drain;

  assign last_beat = (cnt_q == OCH_W'(OCH_DEPTH - 1));
  assign hs        = drain_vld & omem.drain_ready;
  assign wr_en     = omem.pea2omem.out_valid & ~drain_vld;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_ACC;
    else     state_q <= state_d;
  end

  // A write coinciding with center_done still lands: wr_en is gated by the current state.
  always_comb begin
    state_d   = state_q;
    drain_vld = 1'b0;
    case (state_q)
      ST_ACC: begin
        if (omem.center_done) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        drain_vld = 1'b1;
        if (omem.drain_ready && last_beat) state_d = ST_ACC;
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      acc_valid_q <= 1'b0;
      drop_err_q  <= 1'b0;
    end else begin
      if (hs) cnt_q <= last_beat ? '0 : cnt_q + 1'b1;
      acc_valid_q <= omem.rd_en;
      if (drain_vld && omem.pea2omem.out_valid) drop_err_q <= 1'b1;
    end
  end

  for (genvar i = 0; i < PE_NUM; i++) begin : g_lane
    omem_bank u_bank (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .wr_ch     (omem.pea2omem.out_ch[i]),
      .wr_dat    (omem.pea2omem.ofmap[i]),
      .rd_en     (omem.rd_en),
      .rd_ch     (omem.rd_ch[i*OCH_W +: OCH_W]),
      .rd_psum   (rd_psum[i]),
      .drain_ch  (cnt_q),
      .drain_clr (hs),
      .drain_dat (bank_drain[i])
    );
  end

  assign omem.omem2pea    = '{psum: rd_psum, acc_valid: acc_valid_q};
  assign omem.busy        = drain_vld;
  assign omem.drain_valid = drain_vld;
  assign omem.drain_ch    = cnt_q;
  assign omem.drain_last  = drain_vld & last_beat;
  assign omem.drain_data  = drain_vld ? bank_drain : '0;
  assign omem.wr_drop_err = drop_err_q;
endmodule
